// File: rtl/fifo_rr_ctrl.sv
// fifo_rr_ctrl: round-robin two-requester write arbiter and pointer/flag controller
// for a single-clock FIFO built on an async-read, sync-write dual-port memory.
module fifo_rr_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  output logic                  gnt_a,
  input  logic                  req_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic                  gnt_b,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic                  mem_wen,
  output logic                  mem_full,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  underflow
);
  localparam logic [ADDR_WIDTH:0] ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] AFULL = (ADDR_WIDTH+1)'(AFULL_LEVEL);
  logic [ADDR_WIDTH:0] wptr, rptr;
  logic last_gnt;
  logic pop;
  always_comb begin
    empty       = wptr == rptr;
    full        = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) && (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
    count       = wptr - rptr;
    almost_full = count >= AFULL;
    // on a tie the requester that did not win last time goes first
    gnt_a       = ~full & req_a & (~req_b | last_gnt);
    gnt_b       = ~full & req_b & (~req_a | ~last_gnt);
    mem_wen     = gnt_a | gnt_b;
    mem_full    = full;
    mem_wdata   = gnt_b ? data_b : data_a;
    mem_waddr   = wptr[ADDR_WIDTH-1:0];
    mem_raddr   = rptr[ADDR_WIDTH-1:0];
    pop         = rd_en & ~empty;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      last_gnt  <= 1'b1;
      underflow <= 1'b0;
    end else begin
      if (mem_wen) begin
        wptr     <= wptr + ONE;
        last_gnt <= gnt_b;
      end
      if (pop) rptr <= rptr + ONE;
      if (rd_en & empty) underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fifo_rr_ctrl.sv
// tb_fifo_rr_ctrl: directed and randomized checks of fifo_rr_ctrl against a queue-based model.
module tb_fifo_rr_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_a = 1'b0, req_b = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] data_a = '0, data_b = '0;
  logic gnt_a, gnt_b, mem_wen, mem_full, full, empty, almost_full, underflow;
  logic [3:0] mem_waddr, mem_raddr;
  logic [7:0] mem_wdata;
  logic [4:0] count;
  logic [7:0] mem [16];
  int n_vec = 0, n_err = 0;
  logic [7:0] q[$];
  int wr_n = 0, rd_n = 0;
  bit last_b = 1'b1, uf = 1'b0;
  fifo_rr_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .data_a(data_a), .gnt_a(gnt_a),
    .req_b(req_b), .data_b(data_b), .gnt_b(gnt_b),
    .rd_en(rd_en), .clr_err(clr_err),
    .mem_wen(mem_wen), .mem_full(mem_full),
    .mem_waddr(mem_waddr), .mem_raddr(mem_raddr), .mem_wdata(mem_wdata),
    .full(full), .empty(empty), .almost_full(almost_full),
    .count(count), .underflow(underflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_wen) mem[mem_waddr] <= mem_wdata;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input bit ra, input logic [7:0] da, input bit rb, input logic [7:0] db,
                      input bit rd, input bit clr, output bit ga, output bit gb);
    bit fm, em;
    req_a = ra; data_a = da; req_b = rb; data_b = db; rd_en = rd; clr_err = clr;
    fm = q.size() == 16;
    em = q.size() == 0;
    ga = 1'b0;
    gb = 1'b0;
    if (!fm) begin
      if (ra && rb) begin ga = last_b; gb = !last_b; end
      else begin ga = ra; gb = rb; end
    end
    @(negedge clk);
    chk("gnt_a", 32'(gnt_a), 32'(ga));
    chk("gnt_b", 32'(gnt_b), 32'(gb));
    chk("mem_wen", 32'(mem_wen), 32'(ga | gb));
    chk("mem_wdata", 32'(mem_wdata), 32'(gb ? db : da));
    chk("full", 32'(full), 32'(fm));
    chk("mem_full", 32'(mem_full), 32'(fm));
    chk("empty", 32'(empty), 32'(em));
    chk("count", 32'(count), q.size());
    chk("almost_full", 32'(almost_full), 32'(q.size() >= 12));
    chk("underflow", 32'(underflow), 32'(uf));
    chk("mem_waddr", 32'(mem_waddr), wr_n % 16);
    chk("mem_raddr", 32'(mem_raddr), rd_n % 16);
    if (rd && !em) chk("rdata", 32'(mem[mem_raddr]), 32'(q[0]));
    @(posedge clk);
    if (rd && !em) begin void'(q.pop_front()); rd_n++; end
    if (ga) begin q.push_back(da); wr_n++; last_b = 1'b0; end
    if (gb) begin q.push_back(db); wr_n++; last_b = 1'b1; end
    if (rd && em) uf = 1'b1;
    else if (clr) uf = 1'b0;
    #1;
  endtask
  // reset is asserted mid-cycle and its effect checked before any clock edge
  task automatic do_reset();
    req_a = 0; req_b = 0; rd_en = 0; clr_err = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_afull", 32'(almost_full), 0);
    chk("rst_uflow", 32'(underflow), 0);
    chk("rst_wen", 32'(mem_wen | gnt_a | gnt_b), 0);
    chk("rst_raddr", 32'(mem_raddr), 0);
    q.delete(); wr_n = 0; rd_n = 0; last_b = 1'b1; uf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bit ga, gb, pa, pb, rd;
    logic [7:0] da, db;
    int sa = 0, sb = 0;
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 8'(8'h10 + i), 1, 8'(8'h90 + i), 0, 0, ga, gb);
    step(0, 8'h00, 1, 8'h99, 0, 0, ga, gb);
    for (int i = 0; i < 5; i++) step(0, 8'h00, 0, 8'h00, 1, 0, ga, gb);
    for (int i = 0; i < 17; i++) step(1, 8'(8'h20 + i), 0, 8'h00, 0, 0, ga, gb);
    step(1, 8'h40, 0, 8'h00, 1, 0, ga, gb);
    step(1, 8'h40, 0, 8'h00, 0, 0, ga, gb);
    for (int i = 0; i < 8; i++) step(0, 8'h00, 0, 8'h00, 1, 0, ga, gb);
    for (int i = 0; i < 5; i++) step(1, 8'(8'h50 + i), 0, 8'h00, 1, 0, ga, gb);
    for (int i = 0; i < 9; i++) step(0, 8'h00, 0, 8'h00, 1, 0, ga, gb);
    step(0, 8'h00, 0, 8'h00, 1, 0, ga, gb);
    step(0, 8'h00, 0, 8'h00, 0, 1, ga, gb);
    step(0, 8'h00, 0, 8'h00, 1, 1, ga, gb);
    step(0, 8'h00, 0, 8'h00, 0, 1, ga, gb);
    for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 8'(8'h60 + i), 0, 0, ga, gb);
    step(0, 8'h00, 0, 8'h00, 0, 0, ga, gb);
    do_reset();
    pa = 0; pb = 0; da = 0; db = 0;
    for (int i = 0; i < 800; i++) begin
      if (!pa) begin pa = $urandom_range(0, 3) != 0; da = {1'b0, 7'(sa)}; sa++; end
      if (!pb) begin pb = $urandom_range(0, 3) != 0; db = {1'b1, 7'(sb)}; sb++; end
      rd = ((i / 100) % 2) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
      step(pa, da, pb, db, rd, $urandom_range(0, 15) == 0, ga, gb);
      if (ga) pa = 0;
      if (gb) pb = 0;
    end
    for (int i = 0; i < 20; i++) step(0, 8'h00, 0, 8'h00, 1, 0, ga, gb);
    chk("final_empty", 32'(empty), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
